// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// Shared definitions for the nibble-serial adder: FSM state encoding,
// slice width and the default operand size in nibbles.
package add_pkg;
  localparam int SLICE_W     = 4;
  localparam int NIBBLES_DEF = 4;
  localparam int STATE_W     = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;
endpackage

// File: rtl/nibble_serial_adder_ctrl_add4.sv
// Combinational 4-bit adder slice shared by every nibble of the wide add.
module nibble_add4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);
  assign {co, s} = {1'b0, a} + {1'b0, b} + {4'b0000, ci};
endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Wide adder sequencer: one 4-bit slice processes a nibble per clock, LSB first,
// with the inter-nibble carry held in a register.
module nibble_serial_adder_ctrl
  import add_pkg::*;
#(
  parameter  int NIBBLES = NIBBLES_DEF,
  localparam int W       = SLICE_W * NIBBLES,
  localparam int CNT_W   = $clog2(NIBBLES)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] sum,
  output logic         cout
);

  localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(NIBBLES - 1);

  state_e               state_q;
  logic [W-1:0]         a_sh_q;
  logic [W-1:0]         b_sh_q;
  logic                 carry_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [W-1:0]         sum_q;
  logic                 cout_q;

  logic [SLICE_W-1:0]   nib_d;
  logic                 slice_co_d;

  nibble_add4 u_slice (
    .a  (a_sh_q[SLICE_W-1:0]),
    .b  (b_sh_q[SLICE_W-1:0]),
    .ci (carry_q),
    .s  (nib_d),
    .co (slice_co_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            a_sh_q  <= a;
            b_sh_q  <= b;
            carry_q <= cin;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          // Result nibbles enter at the MSB end so the LSB nibble lands at [3:0] last.
          sum_q   <= {nib_d, sum_q[W-1:SLICE_W]};
          carry_q <= slice_co_d;
          a_sh_q  <= {{SLICE_W{1'b0}}, a_sh_q[W-1:SLICE_W]};
          b_sh_q  <= {{SLICE_W{1'b0}}, b_sh_q[W-1:SLICE_W]};
          cnt_q   <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST_NIB) begin
            cout_q  <= slice_co_d;
            state_q <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Randomized self-checking bench for the nibble-serial adder at NIBBLES=4 and NIBBLES=2.
module tb_nibble_serial_adder_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        start4 = 1'b0;
  logic [15:0] a4 = '0, b4 = '0;
  logic        cin4 = 1'b0;
  logic        busy4, done4, cout4;
  logic [15:0] sum4;

  logic        start2 = 1'b0;
  logic [7:0]  a2 = '0, b2 = '0;
  logic        cin2 = 1'b0;
  logic        busy2, done2, cout2;
  logic [7:0]  sum2;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  nibble_serial_adder_ctrl #(.NIBBLES(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
  );

  nibble_serial_adder_ctrl #(.NIBBLES(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .cin(cin2),
    .busy(busy2), .done(done2), .sum(sum2), .cout(cout2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One 16-bit add: checks latency, busy length, result and single-cycle done.
  task automatic add4(input logic [15:0] ta, input logic [15:0] tbv, input logic tc,
                      input bit scramble, input string tag);
    int cyc, nbusy;
    logic [16:0] exp;
    exp = {1'b0, ta} + {1'b0, tbv} + 17'(tc);
    @(negedge clk); a4 = ta; b4 = tbv; cin4 = tc; start4 = 1'b1;
    @(negedge clk); start4 = 1'b0;
    cyc = 0; nbusy = 0;
    while (!done4 && cyc < 20) begin
      if (busy4) nbusy++;
      if (scramble) begin a4 = 16'($urandom); b4 = 16'($urandom); cin4 = 1'($urandom); end
      @(negedge clk); cyc++;
    end
    chk({tag, "_lat"}, cyc, 4);
    chk({tag, "_busy"}, nbusy, 4);
    chk({tag, "_res"}, {cout4, sum4}, exp);
    @(negedge clk);
    chk({tag, "_pulse"}, done4, 0);
    chk({tag, "_hold"}, {cout4, sum4}, exp);
  endtask

  task automatic add2(input logic [7:0] ta, input logic [7:0] tbv, input logic tc, input string tag);
    int cyc;
    logic [8:0] exp;
    exp = {1'b0, ta} + {1'b0, tbv} + 9'(tc);
    @(negedge clk); a2 = ta; b2 = tbv; cin2 = tc; start2 = 1'b1;
    @(negedge clk); start2 = 1'b0;
    cyc = 0;
    while (!done2 && cyc < 20) begin @(negedge clk); cyc++; end
    chk({tag, "_lat"}, cyc, 2);
    chk({tag, "_res"}, {cout2, sum2}, exp);
  endtask

  initial begin
    int cyc, ndone;

    @(negedge clk);
    chk("rst_out4", {busy4, done4, cout4, sum4}, 0);
    chk("rst_out2", {busy2, done2, cout2, sum2}, 0);
    @(negedge clk); rst = 1'b0;

    add4(16'h1234, 16'h4321, 1'b0, 1'b0, "basic");
    add4(16'hFFFF, 16'h0001, 1'b0, 1'b0, "ripple");
    add4(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, "allones");
    add4(16'h8000, 16'h8000, 1'b0, 1'b1, "scramble");

    // Start held high: RUN ignores it, DONE re-accepts back to back.
    @(negedge clk); a4 = 16'h00F0; b4 = 16'h0010; cin4 = 1'b1; start4 = 1'b1;
    @(negedge clk);
    cyc = 0;
    while (!done4 && cyc < 20) begin @(negedge clk); cyc++; end
    chk("held_first", cyc, 4);
    chk("held_res0", {cout4, sum4}, 17'h00101);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      cyc = 1;
      while (!done4 && cyc < 20) begin @(negedge clk); cyc++; end
      chk("held_gap", cyc, 5);
      chk("held_res", {cout4, sum4}, 17'h00101);
    end
    start4 = 1'b0;
    @(negedge clk);
    chk("held_idle", {busy4, done4}, 0);

    // Asynchronous reset in the middle of an operation.
    @(negedge clk); a4 = 16'hABCD; b4 = 16'h1111; cin4 = 1'b0; start4 = 1'b1;
    @(negedge clk); start4 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_out", {busy4, done4, cout4, sum4}, 0);
    @(negedge clk); rst = 1'b0;
    ndone = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done4 || busy4) ndone++;
    end
    chk("midrst_quiet", ndone, 0);
    add4(16'h0001, 16'h0002, 1'b0, 1'b0, "postrst");

    for (int k = 0; k < 10; k++)
      add4(16'($urandom), 16'($urandom), 1'($urandom), 1'b0, "rand4");
    for (int k = 0; k < 10; k++)
      add2(8'($urandom), 8'($urandom), 1'($urandom), "rand2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
